// File: rtl/nrbs_pkg.sv
// Shared definitions for the bit-serial ripple-borrow subtractor.
// Holds the FSM state encoding and the counter-width helper.
package nrbs_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A counter must stay at least one bit wide, even when n=1.
    function automatic int CNT_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nrbs_serial_if.sv
// Start/busy/valid request-result bundle for nrbs_serial.
// The bench drives it through the master view; the subtractor uses the slave view.
interface nrbs_serial_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         valid;
    logic [N-1:0] diff;
    logic         bout;

    modport master (
        output start, a, b, bin,
        input  busy, valid, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, valid, diff, bout
    );
endinterface

// File: rtl/fs_cell.sv
// Combinational one-bit full subtractor: computes a - b - bin.
// Produces the difference bit and the borrow passed on to the next bit.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/nrbs_serial.sv
// Bit-serial n-bit subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell, behind a start/busy/valid handshake.
module nrbs_serial
    import nrbs_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    nrbs_serial_if.slave bus
);
    localparam int              CW       = CNT_W(n);
    localparam logic [CW-1:0]   CNT_LAST = CW'(n - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [n-1:0]   r_a_sh;
    logic [n-1:0]   r_b_sh;
    logic [n-1:0]   r_d_sh;
    logic           r_br;
    logic           r_busy;
    logic           r_valid;
    logic [n-1:0]   r_diff;
    logic           r_bout;

    logic           w_load;
    logic           w_step;
    logic           w_done;
    logic           w_d;
    logic           w_br_next;
    logic [n-1:0]   w_a_sh_next;
    logic [n-1:0]   w_b_sh_next;
    logic [n-1:0]   w_d_sh_next;

    fs_cell u_fs_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_br_next)
    );

    // Operands drain towards bit 0; result bits enter at the MSB so that
    // after n steps the first-computed bit has reached bit 0.
    generate
        if (n == 1) begin : g_shift_one
            assign w_a_sh_next = 1'b0;
            assign w_b_sh_next = 1'b0;
            assign w_d_sh_next = w_d;
        end else begin : g_shift_wide
            assign w_a_sh_next = {1'b0, r_a_sh[n-1:1]};
            assign w_b_sh_next = {1'b0, r_b_sh[n-1:1]};
            assign w_d_sh_next = {w_d, r_d_sh[n-1:1]};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_RUN;
                    w_load       = 1'b1;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_d_sh  <= '0;
            r_br    <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_valid <= w_done;
            if (w_load) begin
                r_a_sh <= bus.a;
                r_b_sh <= bus.b;
                r_br   <= bus.bin;
                r_cnt  <= '0;
                r_d_sh <= '0;
            end else if (w_step) begin
                r_a_sh <= w_a_sh_next;
                r_b_sh <= w_b_sh_next;
                r_d_sh <= w_d_sh_next;
                r_br   <= w_br_next;
                r_cnt  <= r_cnt + CW'(1);
            end
            // Result registers hold until the next completion.
            if (w_done) begin
                r_diff <= w_d_sh_next;
                r_bout <= w_br_next;
            end
        end
    end

    assign bus.busy  = r_busy;
    assign bus.valid = r_valid;
    assign bus.diff  = r_diff;
    assign bus.bout  = r_bout;

endmodule

// File: tb/tb_nrbs_serial.sv
// Directed bench for nrbs_serial: an n=8 instance for the main scenarios and an
// n=1 instance for the exhaustive single-bit table.
module tb_nrbs_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nrbs_serial_if #(.N(8)) ifa ();
    nrbs_serial_if #(.N(1)) ifb ();

    nrbs_serial #(.n(8)) u_dut8 (.clk(clk), .rst(rst), .bus(ifa));
    nrbs_serial #(.n(1)) u_dut1 (.clk(clk), .rst(rst), .bus(ifb));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        ifa.a     = a;
        ifa.b     = b;
        ifa.bin   = bin;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait8(input string tag, input logic [7:0] ed, input logic eb);
        int bad;
        bad = 0;
        while (ifa.valid !== 1'b1 && (cyc - t0) < 20) begin
            if (ifa.busy !== 1'b1) bad++;
            tick();
        end
        chk({tag, " latency"}, cyc - t0, 8);
        chk({tag, " busy_during_run"}, bad, 0);
        chk({tag, " diff"}, ifa.diff, ed);
        chk({tag, " bout"}, ifa.bout, eb);
        chk({tag, " busy_at_valid"}, ifa.busy, 0);
        $display("%s: diff=%0d bout=%0d latency=%0d", tag, ifa.diff, ifa.bout, cyc - t0);
    endtask

    task automatic after_valid(input string tag, input logic [7:0] ed);
        tick();
        chk({tag, " valid_drop"}, ifa.valid, 0);
        chk({tag, " diff_hold"}, ifa.diff, ed);
    endtask

    initial begin
        int vcount;
        int r;
        logic [7:0] ra, rb;
        logic       rbin;
        logic       a1, b1, c1;

        ifa.start = 1'b0; ifa.a = '0; ifa.b = '0; ifa.bin = 1'b0;
        ifb.start = 1'b0; ifb.a = '0; ifb.b = '0; ifb.bin = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        chk("reset busy", ifa.busy, 0);
        chk("reset valid", ifa.valid, 0);
        chk("reset diff", ifa.diff, 0);
        chk("reset bout", ifa.bout, 0);
        $display("reset: busy=%0d valid=%0d diff=%0d bout=%0d", ifa.busy, ifa.valid, ifa.diff, ifa.bout);
        rst = 1'b0;
        tick();

        launch8(8'd20, 8'd10, 1'b0);
        wait8("20-10", 8'd10, 1'b0);
        after_valid("20-10", 8'd10);

        launch8(8'd10, 8'd20, 1'b0);
        wait8("10-20", 8'd246, 1'b1);
        after_valid("10-20", 8'd246);

        launch8(8'd0, 8'd0, 1'b1);
        wait8("0-0-1", 8'd255, 1'b1);
        after_valid("0-0-1", 8'd255);

        // Second request issued in the very cycle the first result is valid.
        launch8(8'd255, 8'd255, 1'b0);
        wait8("255-255", 8'd0, 1'b0);
        launch8(8'd127, 8'd128, 1'b0);
        wait8("127-128 b2b", 8'd255, 1'b1);
        after_valid("127-128 b2b", 8'd255);

        launch8(8'd5, 8'd0, 1'b0);
        tick();
        tick();
        ifa.a = 8'd99; ifa.b = 8'd23; ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        wait8("5-0 midrun", 8'd5, 1'b0);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ifa.valid === 1'b1) vcount++;
        end
        chk("midrun extra valids", vcount, 0);
        chk("midrun busy idle", ifa.busy, 0);

        launch8(8'd14, 8'd1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort valid", ifa.valid, 0);
        chk("abort diff", ifa.diff, 0);
        chk("abort bout", ifa.bout, 0);
        chk("abort busy", ifa.busy, 0);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ifa.valid === 1'b1) vcount++;
        end
        chk("abort no valid", vcount, 0);
        $display("abort: diff=%0d bout=%0d busy=%0d", ifa.diff, ifa.bout, ifa.busy);
        launch8(8'd14, 8'd1, 1'b0);
        wait8("14-1 after abort", 8'd13, 1'b0);
        after_valid("14-1 after abort", 8'd13);

        for (int c = 0; c < 8; c++) begin
            a1 = c[2]; b1 = c[1]; c1 = c[0];
            r  = int'(a1) - int'(b1) - int'(c1);
            ifb.a = a1; ifb.b = b1; ifb.bin = c1; ifb.start = 1'b1;
            tick();
            ifb.start = 1'b0;
            chk("n1 busy", ifb.busy, 1);
            chk("n1 early valid", ifb.valid, 0);
            tick();
            chk("n1 valid", ifb.valid, 1);
            chk("n1 diff", ifb.diff, r & 1);
            chk("n1 bout", ifb.bout, (r < 0) ? 1 : 0);
            chk("n1 busy after", ifb.busy, 0);
            $display("n1: a=%0d b=%0d bin=%0d -> d=%0d bout=%0d", a1, b1, c1, ifb.diff, ifb.bout);
            tick();
        end

        for (int k = 0; k < 10; k++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            r    = int'(ra) - int'(rb) - int'(rbin);
            launch8(ra, rb, rbin);
            wait8($sformatf("rand %0d-%0d-%0d", ra, rb, rbin), 8'(r & 255), (r < 0) ? 1'b1 : 1'b0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
